// File: rtl/mac_west_feeder.sv
// mac_west_feeder: diagonally skewed WS-load / execute / OS-flush sequencer for the west edge of the mac_tile array.
// Optional build macro FEEDER_STALL_CNT_EN adds a saturating stall_cnt output counting starved LOAD/EXEC cycles.
module mac_west_feeder #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_in,
    input  logic [len_bw-1:0] k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [row*bw-1:0] in_data,
    output logic [row*bw-1:0] out_w,
    output logic [2*row-1:0]  inst_w,
    output logic [row-1:0]    mode_out,
    output logic              busy,
    output logic              done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int pw = $clog2(col + 1) > len_bw ? $clog2(col + 1) : len_bw;
    localparam int cw = $clog2(row + 1) > pw ? $clog2(row + 1) : pw;

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, FLUSH, DRAIN} state_t;

    state_t            state, state_n;
    logic [cw-1:0]     cnt, cnt_n;
    logic              mode_q, mode_n;
    logic [len_bw-1:0] k_q, k_n;
    logic [row*bw-1:0] vec_q, vec_n;
    logic [1:0]        inst_q, inst_n;
    logic              m_q, m_n;
    logic              accept;
    logic [cw-1:0]     last_col, last_row, last_k;

    assign last_col = cw'(col - 1);
    assign last_row = cw'(row - 1);
    assign last_k   = cw'(k_q) - cw'(1);
    assign in_ready = (state == LOAD) || (state == EXEC);
    assign accept   = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign done     = (state == DRAIN) && (cnt == last_row);

    // Phase sequencing and the row-0 issue; a starved LOAD/EXEC cycle holds data and mode and issues inst 00
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        k_n     = k_q;
        vec_n   = vec_q;
        inst_n  = 2'b00;
        m_n     = m_q;
        case (state)
            IDLE: begin
                vec_n = '0;
                m_n   = 1'b0;
                if (start) begin
                    mode_n  = mode_in;
                    k_n     = k_len;
                    cnt_n   = '0;
                    state_n = !mode_in ? LOAD : (k_len != '0 ? EXEC : FLUSH);
                end
            end
            LOAD: if (accept) begin
                vec_n  = in_data;
                inst_n = 2'b01;
                m_n    = 1'b0;
                cnt_n  = cnt == last_col ? '0 : cnt + cw'(1);
                if (cnt == last_col) state_n = k_q == '0 ? DRAIN : EXEC;
            end
            EXEC: if (accept) begin
                vec_n  = in_data;
                inst_n = 2'b10;
                m_n    = mode_q;
                cnt_n  = cnt == last_k ? '0 : cnt + cw'(1);
                if (cnt == last_k) state_n = mode_q ? FLUSH : DRAIN;
            end
            FLUSH: begin
                vec_n   = '0;
                inst_n  = 2'b10;
                m_n     = 1'b0;
                cnt_n   = cnt == last_col ? '0 : cnt + cw'(1);
                state_n = cnt == last_col ? DRAIN : FLUSH;
            end
            DRAIN: begin
                vec_n   = '0;
                m_n     = 1'b0;
                cnt_n   = cnt == last_row ? '0 : cnt + cw'(1);
                state_n = cnt == last_row ? IDLE : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, phase counter, latched pass parameters and the registered row-0 stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            k_q    <= '0;
            vec_q  <= '0;
            inst_q <= 2'b00;
            m_q    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            k_q    <= k_n;
            vec_q  <= vec_n;
            inst_q <= inst_n;
            m_q    <= m_n;
        end
    end

    assign out_w[bw-1:0] = vec_q[bw-1:0];
    assign inst_w[1:0]   = inst_q;
    assign mode_out[0]   = m_q;

    for (genvar r = 1; r < row; r++) begin : g_skew
        logic [bw+2:0] sh [r];
        // Row r replays row 0's {data, inst, mode} through an r-deep delay line
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < r; i++) sh[i] <= '0;
            end else begin
                sh[0] <= {vec_q[r*bw +: bw], inst_q, m_q};
                for (int i = 1; i < r; i++) sh[i] <= sh[i-1];
            end
        end
        assign {out_w[r*bw +: bw], inst_w[2*r +: 2], mode_out[r]} = sh[r-1];
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of LOAD/EXEC cycles starved of input, cleared when a pass starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (in_ready && !in_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mac_west_feeder.sv
// tb_mac_west_feeder: randomized bench checking mac_west_feeder every cycle against a token-queue model of a pass.
module tb_mac_west_feeder;
    localparam int BW  = 4;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LBW = 8;
    localparam int DW  = ROW * BW;
    localparam int HN  = 40000;

    typedef struct packed {
        logic       need;
        logic [1:0] inst;
        logic       mode;
    } tok_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           mode_in = 1'b0;
    logic [LBW-1:0] k_len = '0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic [DW-1:0]  out_w;
    logic [2*ROW-1:0] inst_w;
    logic [ROW-1:0] mode_out;
    logic           busy;
    logic           done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    mac_west_feeder #(.bw(BW), .row(ROW), .col(COL), .len_bw(LBW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode_in(mode_in),
        .k_len(k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_w(out_w),
        .inst_w(inst_w),
        .mode_out(mode_out),
        .busy(busy),
`ifdef FEEDER_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    tok_t          q[$];
    logic [DW-1:0] h_vec [HN];
    logic [1:0]    h_inst [HN];
    logic          h_mode [HN];
    logic [DW-1:0] last_vec = '0;
    logic          last_mode = 1'b0;
    int            cyc = 0;
    int            reset_mark = 0;
    int            m_stall = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output at the falling edge
    task automatic step(input logic st, input logic md, input logic [LBW-1:0] kl, input logic vld, input logic [DW-1:0] dat);
        tok_t          t;
        logic [DW-1:0] v;
        logic [1:0]    ni;
        logic          m;
        logic          e_busy, e_done, e_ready;
        int            e_stall, idx;
        logic [DW-1:0] e_w;
        logic [2*ROW-1:0] e_i;
        logic [ROW-1:0] e_m;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        e_busy  = q.size() != 0;
        e_done  = q.size() == 1;
        e_ready = q.size() != 0 && q[0].need;
        e_stall = m_stall;
        start = st;
        mode_in = md;
        k_len = kl;
        in_valid = vld;
        in_data = dat;
        if (q.size() == 0) begin
            v = '0;
            ni = 2'b00;
            m = 1'b0;
            if (st) begin
                for (int i = 0; i < (md ? 0 : COL); i++) q.push_back('{1'b1, 2'b01, 1'b0});
                for (int i = 0; i < int'(kl); i++) q.push_back('{1'b1, 2'b10, md});
                for (int i = 0; i < (md ? COL : 0); i++) q.push_back('{1'b0, 2'b10, 1'b0});
                for (int i = 0; i < ROW; i++) q.push_back('{1'b0, 2'b00, 1'b0});
                m_stall = 0;
            end
        end else if (q[0].need && !vld) begin
            v = last_vec;
            ni = 2'b00;
            m = last_mode;
            if (m_stall < 65535) m_stall++;
        end else begin
            t = q.pop_front();
            v = t.need ? dat : '0;
            ni = t.inst;
            m = t.mode;
        end
        h_vec[cyc] = v;
        h_inst[cyc] = ni;
        h_mode[cyc] = m;
        last_vec = v;
        last_mode = m;
        @(negedge clk);
        e_w = '0;
        e_i = '0;
        e_m = '0;
        for (int r = 0; r < ROW; r++) begin
            idx = cyc - 1 - r;
            if (idx > reset_mark) begin
                e_w[r*BW +: BW] = h_vec[idx][r*BW +: BW];
                e_i[2*r +: 2] = h_inst[idx];
                e_m[r] = h_mode[idx];
            end
        end
        chk("in_ready", in_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("out_w", out_w, e_w);
        chk("inst_w", inst_w, e_i);
        chk("mode_out", mode_out, e_m);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e_stall);
`endif
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_out_w", out_w, 0);
        chk("rst_inst_w", inst_w, 0);
        chk("rst_mode_out", mode_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        q.delete();
        last_vec = '0;
        last_mode = 1'b0;
        m_stall = 0;
        reset_mark = cyc;
    endtask

    // vmode: 0 always valid, 1 valid on alternate cycles, 2 random; abort_at>0 resets after that many cycles
    task automatic run_pass(input logic md, input int kl, input int vmode, input logic fixed, input int abort_at,
                            output int dcyc, output int n_exec7, output int n_load7, output int n_ready);
        int t0;
        logic vld;
        logic [DW-1:0] five;
        five = {ROW{4'h5}};
        dcyc = -1;
        n_exec7 = 0;
        n_load7 = 0;
        n_ready = 0;
        step(1'b1, md, kl[LBW-1:0], 1'b1, $urandom);
        t0 = cyc;
        for (int n = 0; n < 4000; n++) begin
            vld = vmode == 0 ? 1'b1 : vmode == 1 ? cyc[0] : ($urandom_range(3) != 0);
            step($urandom_range(7) == 0, 1'($urandom_range(1)), 8'($urandom_range(255)), vld, fixed ? five : $urandom);
            n_exec7 += int'(inst_w[2*ROW-1 -: 2] == 2'b10);
            n_load7 += int'(inst_w[2*ROW-1 -: 2] == 2'b01);
            n_ready += int'(in_ready);
            if (abort_at > 0 && n + 1 == abort_at) begin
                mid_reset();
                return;
            end
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
        end
        if (dcyc < 0 && abort_at == 0) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout actual=no_done required=done within 4000 cycles");
        end
    endtask

    initial begin
        int d, e, l, rdy;
        #1 reset = 1'b1;
        #1;
        chk("init_out_w", out_w, 0);
        chk("init_inst_w", inst_w, 0);
        chk("init_mode_out", mode_out, 0);
        chk("init_in_ready", in_ready, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        run_pass(1'b0, 4, 0, 1'b0, 0, d, e, l, rdy);
        chk("ws4_done_lat", d, 20);
        chk("ws4_row7_exec", e, 4);
        chk("ws4_row7_load", l, 8);
        run_pass(1'b1, 3, 0, 1'b1, 0, d, e, l, rdy);
        chk("os3_done_lat", d, 19);
        chk("os3_row7_exec", e, 11);
        chk("os3_row7_load", l, 0);
        run_pass(1'b0, 5, 1, 1'b0, 0, d, e, l, rdy);
        chk("wsalt_row7_exec", e, 5);
        chk("wsalt_row7_load", l, 8);
        run_pass(1'b1, 0, 2, 1'b0, 0, d, e, l, rdy);
        chk("os0_done_lat", d, 16);
        chk("os0_row7_flush", e, 8);
        chk("os0_ready_cycles", rdy, 0);
        run_pass(1'b0, 20, 0, 1'b0, 12, d, e, l, rdy);
        run_pass(1'b0, 4, 0, 1'b0, 0, d, e, l, rdy);
        chk("post_rst_done_lat", d, 20);
        chk("post_rst_row7_exec", e, 4);
        run_pass(1'b0, 255, 0, 1'b0, 0, d, e, l, rdy);
        chk("ws255_done_lat", d, 271);
        chk("ws255_row7_exec", e, 255);
        run_pass(1'b0, 0, 0, 1'b0, 0, d, e, l, rdy);
        chk("ws0_done_lat", d, 16);
        repeat (14) begin
            run_pass(1'($urandom_range(1)), $urandom_range(24), 2, 1'b0, 0, d, e, l, rdy);
            repeat ($urandom_range(3)) step(1'b0, 1'b0, '0, 1'($urandom_range(1)), $urandom);
        end
        repeat (ROW + 2) step(1'b0, 1'b0, '0, 1'b1, $urandom);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
